// File: rtl/pc_sequencer.sv
// Program-counter stage with next-PC selection and a run / single-step / fault sequencer.
// The commit strobe qualifies every architectural write of the current instruction.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        step_mode,
    input  logic        step_req,
    input  logic        Branch,
    input  logic        BranchNE,
    input  logic        Jump,
    input  logic        jumpRA,
    input  logic        zero,
    input  logic [31:0] imm_ext,
    input  logic [25:0] jump_index,
    input  logic [31:0] rs_data,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        commit,
    output logic        paused,
    output logic [1:0]  fault_code,
    output logic [31:0] retired
);

    localparam logic [31:0] IMEM_BYTES = 32'(4 * IMEM_DEPTH);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PAUSE = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] next_pc;
    logic [31:0] pc_offset;
    logic        misaligned;
    logic        out_of_range;
    logic        bad;
    logic        wants_commit;

    always_comb begin
        pc_plus4 = pc + 32'd4;
        next_pc  = pc_plus4;
        if (jumpRA) begin
            next_pc = rs_data;
        end else if (Jump) begin
            next_pc = {pc_plus4[31:28], jump_index, 2'b00};
        end else if ((Branch & zero) | (BranchNE & ~zero)) begin
            next_pc = pc_plus4 + (imm_ext << 2);
        end
    end

    // Offset from RESET_PC is unsigned, so targets below the base wrap high and fail the bound.
    always_comb begin
        pc_offset    = next_pc - RESET_PC;
        misaligned   = (next_pc[1:0] != 2'b00);
        out_of_range = (pc_offset >= IMEM_BYTES);
        bad          = misaligned | out_of_range;
    end

    always_comb begin
        wants_commit = 1'b0;
        case (state)
            RUN:     wants_commit = ~step_mode;
            PAUSE:   wants_commit = step_mode & step_req;
            default: wants_commit = 1'b0;
        endcase
        commit = wants_commit & ~bad;
        paused = (state == PAUSE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            pc         <= RESET_PC;
            retired    <= 32'd0;
            fault_code <= 2'b00;
        end else begin
            case (state)
                RUN: begin
                    if (step_mode) begin
                        state <= PAUSE;
                    end
                end
                PAUSE: begin
                    if (!step_mode) begin
                        state <= RUN;
                    end
                end
                default: state <= FAULT;
            endcase
            // A would-be commit with a bad target locks the sequencer until reset.
            if (wants_commit) begin
                if (bad) begin
                    state      <= FAULT;
                    fault_code <= misaligned ? 2'b01 : 2'b10;
                end else begin
                    pc      <= next_pc;
                    retired <= retired + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, hand-written stepping/fault sequences,
// and randomized cycles checked against a behavioural model.
module tb_pc_sequencer;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int          IMEM_DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        step_mode;
    logic        step_req;
    logic        Branch;
    logic        BranchNE;
    logic        Jump;
    logic        jumpRA;
    logic        zero;
    logic [31:0] imm_ext;
    logic [25:0] jump_index;
    logic [31:0] rs_data;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        commit;
    logic        paused;
    logic [1:0]  fault_code;
    logic [31:0] retired;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pc_sequencer #(
        .RESET_PC  (RESET_PC),
        .IMEM_DEPTH(IMEM_DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .step_mode (step_mode),
        .step_req  (step_req),
        .Branch    (Branch),
        .BranchNE  (BranchNE),
        .Jump      (Jump),
        .jumpRA    (jumpRA),
        .zero      (zero),
        .imm_ext   (imm_ext),
        .jump_index(jump_index),
        .rs_data   (rs_data),
        .pc        (pc),
        .pc_plus4  (pc_plus4),
        .commit    (commit),
        .paused    (paused),
        .fault_code(fault_code),
        .retired   (retired)
    );

    typedef struct {
        int          pre;
        logic        br;
        logic        bne;
        logic        j;
        logic        jra;
        logic        z;
        logic [31:0] imm;
        logic [25:0] ji;
        logic [31:0] rs;
        logic        exp_commit;
        logic [31:0] exp_pc;
        logic [1:0]  exp_fault;
    } vec_t;

    vec_t vecs[11];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic sm, input logic sr,
                                 input logic br, input logic bne, input logic j,
                                 input logic jra, input logic z, input logic [31:0] imm,
                                 input logic [25:0] ji, input logic [31:0] rs);
        reset      = r;
        step_mode  = sm;
        step_req   = sr;
        Branch     = br;
        BranchNE   = bne;
        Jump       = j;
        jumpRA     = jra;
        zero       = z;
        imm_ext    = imm;
        jump_index = ji;
        rs_data    = rs;
    endtask

    // Advances one clock: combinational outputs compared at the falling edge, then returns #1 after the rising edge.
    task automatic runCycle(input bit chk, input logic exp_commit, input logic exp_paused, input string tag);
        @(negedge clk);
        if (chk) begin
            checkOutput({tag, ".commit"}, 32'(commit), 32'(exp_commit));
            checkOutput({tag, ".paused"}, 32'(paused), 32'(exp_paused));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 32'd0, 26'd0, 32'd0);
        runCycle(0, 0, 0, "reset");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 32'd0, 26'd0, 32'd0);
    endtask

    task automatic plainCycle(input logic sm, input logic sr, input logic exp_commit,
                              input logic exp_paused, input string tag);
        applyStimulus(0, sm, sr, 0, 0, 0, 0, 0, 32'd0, 26'd0, 32'd0);
        runCycle(1, exp_commit, exp_paused, tag);
    endtask

    // Behavioural reference: mode 0 running, 1 paused, 2 faulted.
    logic [31:0] m_pc;
    logic [31:0] m_ret;
    logic [1:0]  m_fault;
    int          m_mode;

    function automatic logic [31:0] refTarget(input logic [31:0] cur, input logic br, input logic bne,
                                              input logic j, input logic jra, input logic z,
                                              input logic [31:0] imm, input logic [25:0] ji,
                                              input logic [31:0] rs);
        logic [31:0] seq;
        seq = cur + 32'd4;
        if (jra) return rs;
        if (j) return (seq & 32'hF000_0000) | (32'(ji) * 32'd4);
        if ((br && z) || (bne && !z)) return seq + imm * 32'd4;
        return seq;
    endfunction

    initial begin
        logic        r, sm, sr, br, bne, j, jra, z;
        logic [31:0] imm, rs, tgt;
        logic [25:0] ji;
        logic        eligible, tbad, tmis;

        vecs[0]  = '{2, 1, 0, 0, 0, 1, 32'hFFFF_FFFE, 26'd0, 32'd0,     1, 32'h04, 2'b00};
        vecs[1]  = '{2, 1, 0, 0, 0, 0, 32'hFFFF_FFFE, 26'd0, 32'd0,     1, 32'h0C, 2'b00};
        vecs[2]  = '{2, 0, 1, 0, 0, 0, 32'd3,         26'd0, 32'd0,     1, 32'h18, 2'b00};
        vecs[3]  = '{4, 0, 0, 1, 1, 0, 32'd0,         26'd5, 32'h20,    1, 32'h20, 2'b00};
        vecs[4]  = '{4, 0, 0, 1, 0, 0, 32'd0,         26'd5, 32'h20,    1, 32'h14, 2'b00};
        vecs[5]  = '{0, 0, 0, 0, 1, 0, 32'd0,         26'd0, 32'h22,    0, 32'h00, 2'b01};
        vecs[6]  = '{0, 0, 0, 0, 1, 0, 32'd0,         26'd0, 32'h100,   0, 32'h00, 2'b10};
        vecs[7]  = '{1, 0, 1, 0, 0, 1, 32'd7,         26'd0, 32'd0,     1, 32'h08, 2'b00};
        vecs[8]  = '{0, 0, 0, 0, 1, 0, 32'd0,         26'd0, 32'hFC,    1, 32'hFC, 2'b00};
        vecs[9]  = '{0, 0, 0, 0, 1, 0, 32'd0,         26'd0, 32'h103,   0, 32'h00, 2'b01};
        vecs[10] = '{0, 1, 0, 0, 0, 1, 32'hFFFF_FFFE, 26'd0, 32'd0,     0, 32'h00, 2'b10};

        // Free run from reset.
        doReset();
        checkOutput("rst.pc", pc, 32'h0);
        checkOutput("rst.retired", retired, 32'h0);
        checkOutput("rst.fault", 32'(fault_code), 32'h0);
        checkOutput("rst.paused", 32'(paused), 32'h0);
        for (int k = 0; k < 4; k++) begin
            plainCycle(0, 0, 1, 0, "run");
            checkOutput("run.pc", pc, 32'(4 * (k + 1)));
        end
        checkOutput("run.retired", retired, 32'd4);

        // Enter single-step, hold, then three steps.
        plainCycle(1, 0, 0, 0, "enter_pause");
        checkOutput("pause.paused", 32'(paused), 32'h1);
        for (int k = 0; k < 20; k++) plainCycle(1, 0, 0, 1, "hold");
        checkOutput("hold.pc", pc, 32'h10);
        for (int k = 0; k < 3; k++) begin
            plainCycle(1, 1, 1, 1, "step");
            plainCycle(1, 0, 0, 1, "step_gap");
        end
        checkOutput("step.pc", pc, 32'h1C);
        checkOutput("step.retired", retired, 32'd7);
        plainCycle(0, 1, 0, 1, "resume");
        checkOutput("resume.pc", pc, 32'h1C);
        checkOutput("resume.paused", 32'(paused), 32'h0);
        plainCycle(0, 0, 1, 0, "after_resume");
        checkOutput("after_resume.pc", pc, 32'h20);

        // Fault lock-up and recovery.
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 32'd0, 26'd0, 32'h22);
        runCycle(1, 0, 0, "fault");
        checkOutput("fault.code", 32'(fault_code), 32'h1);
        checkOutput("fault.pc", pc, 32'h20);
        for (int k = 0; k < 3; k++) plainCycle(0, 1, 0, 0, "frozen");
        checkOutput("frozen.pc", pc, 32'h20);
        checkOutput("frozen.retired", retired, 32'd8);
        doReset();
        checkOutput("recover.pc", pc, 32'h0);
        checkOutput("recover.fault", 32'(fault_code), 32'h0);
        checkOutput("recover.paused", 32'(paused), 32'h0);
        checkOutput("recover.retired", retired, 32'h0);

        // Directed next-PC vectors.
        foreach (vecs[v]) begin
            doReset();
            for (int k = 0; k < vecs[v].pre; k++) plainCycle(0, 0, 1, 0, "vec_pre");
            applyStimulus(0, 0, 0, vecs[v].br, vecs[v].bne, vecs[v].j, vecs[v].jra, vecs[v].z,
                          vecs[v].imm, vecs[v].ji, vecs[v].rs);
            runCycle(1, vecs[v].exp_commit, 0, $sformatf("vec%0d", v));
            checkOutput($sformatf("vec%0d.pc", v), pc, vecs[v].exp_pc);
            checkOutput($sformatf("vec%0d.fault", v), 32'(fault_code), 32'(vecs[v].exp_fault));
        end

        // Randomized cycles against the reference model.
        doReset();
        m_pc = RESET_PC; m_ret = 0; m_fault = 0; m_mode = 0;
        sm = 0;
        for (int i = 0; i < 600; i++) begin
            r   = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 11) == 0) sm = ~sm;
            sr  = ($urandom_range(0, 2) == 0);
            br  = ($urandom_range(0, 3) == 0);
            bne = ($urandom_range(0, 3) == 0);
            j   = ($urandom_range(0, 7) == 0);
            jra = ($urandom_range(0, 9) == 0);
            z   = $urandom_range(0, 1);
            imm = 32'($urandom_range(0, 16)) - 32'd8;
            ji  = 26'($urandom_range(0, 66));
            rs  = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 300)) : 32'($urandom_range(0, 63)) * 32'd4;

            tgt      = refTarget(m_pc, br, bne, j, jra, z, imm, ji, rs);
            tmis     = (tgt % 32'd4) != 0;
            tbad     = tmis || (tgt - RESET_PC) >= 32'(4 * IMEM_DEPTH);
            eligible = (m_mode == 0 && !sm) || (m_mode == 1 && sm && sr);

            applyStimulus(r, sm, sr, br, bne, j, jra, z, imm, ji, rs);
            runCycle(!r, eligible && !tbad, m_mode == 1, "rand");

            if (r) begin
                m_pc = RESET_PC; m_ret = 0; m_fault = 0; m_mode = 0;
            end else if (eligible && tbad) begin
                m_mode  = 2;
                m_fault = tmis ? 2'b01 : 2'b10;
            end else if (eligible) begin
                m_pc  = tgt;
                m_ret = m_ret + 1;
            end else if (m_mode == 0 && sm) begin
                m_mode = 1;
            end else if (m_mode == 1 && !sm) begin
                m_mode = 0;
            end
            checkOutput("rand.pc", pc, m_pc);
            checkOutput("rand.retired", retired, m_ret);
            checkOutput("rand.fault", 32'(fault_code), 32'(m_fault));
            checkOutput("rand.pc_plus4", pc_plus4, m_pc + 32'd4);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
